// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the branch sequencer: FSM states, branch function
// codes, instruction field positions and the offset sign-extension helper.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    localparam logic [5:0] BR_OPC_DEFAULT = 6'b000001;

    localparam logic [5:0] BR_U    = 6'b000100;
    localparam logic [5:0] BR_NEG  = 6'b000101;
    localparam logic [5:0] BR_POS  = 6'b000110;
    localparam logic [5:0] BR_Z    = 6'b000111;
    localparam logic [5:0] BR_HALT = 6'b111111;

    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 26;
    localparam int RS_MSB   = 25;
    localparam int RS_LSB   = 21;
    localparam int OFF_MSB  = 20;
    localparam int OFF_LSB  = 6;
    localparam int FUNC_MSB = 5;
    localparam int FUNC_LSB = 0;

    localparam int OFF_W = OFF_MSB - OFF_LSB + 1;

    // PC-relative offsets are 15-bit two's complement words.
    function automatic logic [31:0] sext_offset(input logic [31:0] instr);
        logic [OFF_W-1:0] off;
        off = instr[OFF_MSB:OFF_LSB];
        return {{(32-OFF_W){off[OFF_W-1]}}, off};
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch resolution: condition on the rs value, target
// selection and classification of halt / unknown function codes.
module branch_cond_eval
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0]  func,
    input  logic [31:0] rf_rdata,
    input  logic [31:0] pc,
    input  logic [31:0] offset,
    output logic        taken,
    output logic        illegal,
    output logic        halt,
    output logic [31:0] next_pc
);

    logic rs_neg;
    logic rs_zero;

    assign rs_neg  = rf_rdata[31];
    assign rs_zero = (rf_rdata == 32'd0);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        halt    = 1'b0;
        case (func)
            BR_U:    taken = 1'b1;
            BR_NEG:  taken = rs_neg;
            BR_POS:  taken = !rs_neg && !rs_zero;
            BR_Z:    taken = rs_zero;
            BR_HALT: halt  = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    // Halt keeps the PC pointing at the halt instruction itself.
    always_comb begin
        if (halt)
            next_pc = pc;
        else if (taken)
            next_pc = pc + offset;
        else
            next_pc = pc + 32'd1;
    end

endmodule

// File: rtl/branch_sequencer.sv
// Handshaked fetch/decode/branch controller owning the program counter.
// Optional taken-branch counter enabled by defining BRANCH_PERF_EN.
module branch_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter logic [5:0]  BR_OPC   = BR_OPC_DEFAULT,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic        exec_start,
    input  logic        exec_done,
    output logic [31:0] ir,
    output logic [31:0] pc,
    output logic        halted,
    output logic        illegal
`ifdef BRANCH_PERF_EN
    ,
    output logic [31:0] taken_count
`endif
);

    state_t      state;
    logic        is_branch;
    logic        br_taken;
    logic        br_illegal;
    logic        br_halt;
    logic [31:0] br_next_pc;
    logic [31:0] br_offset;

    assign is_branch = (ir[OPC_MSB:OPC_LSB] == BR_OPC);
    assign br_offset = sext_offset(ir);

    branch_cond_eval u_cond (
        .func     (ir[FUNC_MSB:FUNC_LSB]),
        .rf_rdata (rf_rdata),
        .pc       (pc),
        .offset   (br_offset),
        .taken    (br_taken),
        .illegal  (br_illegal),
        .halt     (br_halt),
        .next_pc  (br_next_pc)
    );

    // Handshake strobes decode the state but are forced low while reset is held.
    assign imem_req   = (state == ST_FETCH) && !rst;
    assign exec_start = (state == ST_DECODE) && !is_branch && !rst;
    assign illegal    = (state == ST_DECODE) && is_branch && br_illegal && !rst;

    assign imem_addr = pc;
    assign rf_raddr  = ir[RS_MSB:RS_LSB];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_FETCH;
            pc     <= RESET_PC;
            ir     <= 32'd0;
            halted <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (is_branch) begin
                        pc <= br_next_pc;
                        if (br_halt) begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        pc    <= pc + 32'd1;
                        state <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

`ifdef BRANCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            taken_count <= 32'd0;
        else if (state == ST_DECODE && is_branch && br_taken)
            taken_count <= taken_count + 32'd1;
    end
`else
    // Taken status only feeds the optional counter; sink it here otherwise.
    logic unused_taken;
    assign unused_taken = br_taken;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: branches, stalls, wrap-around,
// illegal/halt codes and reset during a stalled fetch.
module tb_branch_sequencer;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        exec_start;
    logic        exec_done;
    logic [31:0] ir;
    logic [31:0] pc;
    logic        halted;
    logic        illegal;
`ifdef BRANCH_PERF_EN
    logic [31:0] taken_count;
`endif

    int checks = 0;
    int errors = 0;

    branch_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata),
        .exec_start (exec_start),
        .exec_done  (exec_done),
        .ir         (ir),
        .pc         (pc),
        .halted     (halted),
        .illegal    (illegal)
`ifdef BRANCH_PERF_EN
        ,
        .taken_count(taken_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic check_tc(input logic [31:0] expected);
`ifdef BRANCH_PERF_EN
        check("taken_count", taken_count, expected);
`else
        if (expected == 32'hFFFF_FFFF) $display("unreachable");
`endif
    endtask

    // Called on a falling edge while in FETCH; returns on the falling edge of DECODE.
    task automatic fetch(input logic [31:0] instr, input int nwait, input logic [31:0] exp_pc);
        imem_ack = 1'b0;
        repeat (nwait) @(negedge clk);
        check("fetch_req", {31'd0, imem_req}, 32'd1);
        check("fetch_addr", imem_addr, exp_pc);
        imem_ack   = 1'b1;
        imem_rdata = instr;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        check("ir_latch", ir, instr);
        $display("fetch instr=0x%08h pc=0x%08h", instr, exp_pc);
    endtask

    task automatic branch(input logic [31:0] instr, input logic [31:0] rs,
                          input logic [31:0] pc_before, input logic [31:0] pc_after);
        logic [4:0] rs_idx;
        rs_idx   = instr[25:21];
        rf_rdata = rs;
        fetch(instr, 0, pc_before);
        check("br_raddr", {27'd0, rf_raddr}, {27'd0, rs_idx});
        check("br_no_start", {31'd0, exec_start}, 32'd0);
        check("br_no_illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        check("br_pc", pc, pc_after);
        check("br_addr", imem_addr, pc_after);
        $display("branch instr=0x%08h rs=0x%08h pc 0x%08h -> 0x%08h", instr, rs, pc_before, pc);
    endtask

    initial begin
        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        rf_rdata   = 32'd0;
        exec_done  = 1'b0;

        @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_ir", ir, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_start", {31'd0, exec_start}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check_tc(32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_req", {31'd0, imem_req}, 32'd1);

        // Unconditional and conditional branches.
        branch(32'h0400_0044, 32'd0, 32'd0, 32'd1);
        check_tc(32'd1);
        branch(32'h0400_0244, 32'd0, 32'd1, 32'd10);
        branch(32'h047F_FF85, 32'h8000_0000, 32'd10, 32'd8);
        branch(32'h0400_0084, 32'd0, 32'd8, 32'd10);
        branch(32'h047F_FF85, 32'd5, 32'd10, 32'd11);
        check_tc(32'd4);

        // Non-branch with fetch wait states and exec_done four cycles late.
        fetch(32'h2000_0000, 2, 32'd11);
        check("nb_start", {31'd0, exec_start}, 32'd1);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("nb_start_low", {31'd0, exec_start}, 32'd0);
            check("nb_pc_hold", pc, 32'd11);
            @(negedge clk);
        end
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        check("nb_pc_inc", pc, 32'd12);
        check("nb_req", {31'd0, imem_req}, 32'd1);
        $display("nonbranch delayed done pc=0x%08h", pc);

        // Wrap-around through non-branch and a taken BR_Z.
        branch(32'h041F_FCC4, 32'd0, 32'd12, 32'hFFFF_FFFF);
        fetch(32'h2000_0000, 0, 32'hFFFF_FFFF);
        check("wrap_start", {31'd0, exec_start}, 32'd1);
        @(negedge clk);
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        check("wrap_addr", imem_addr, 32'd0);
        $display("nonbranch wrap pc=0x%08h", pc);
        branch(32'h041F_FFC4, 32'd0, 32'd0, 32'hFFFF_FFFF);
        branch(32'h0400_0087, 32'd0, 32'hFFFF_FFFF, 32'd1);

        // BR_POS taken / not taken, BR_Z not taken.
        branch(32'h0400_00C6, 32'd5, 32'd1, 32'd4);
        branch(32'h0400_00C6, 32'd0, 32'd4, 32'd5);
        branch(32'h0400_0087, 32'd5, 32'd5, 32'd6);
        check_tc(32'd8);

        // Unknown function code; a stray ack in DECODE must be ignored.
        fetch(32'h0400_0008, 0, 32'd6);
        check("ill_pulse", {31'd0, illegal}, 32'd1);
        check("ill_no_start", {31'd0, exec_start}, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        check("ill_clear", {31'd0, illegal}, 32'd0);
        check("ill_pc", pc, 32'd7);
        check("ill_ir_keep", ir, 32'h0400_0008);
        $display("illegal pc=0x%08h", pc);

        // Halt: terminal, no requests even with a stray ack.
        fetch(32'h0400_003F, 0, 32'd7);
        check("halt_no_illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        imem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("halt_flag", {31'd0, halted}, 32'd1);
            check("halt_req", {31'd0, imem_req}, 32'd0);
            check("halt_pc", pc, 32'd7);
            check("halt_start", {31'd0, exec_start}, 32'd0);
            @(negedge clk);
        end
        imem_ack = 1'b0;
        $display("halt pc=0x%08h halted=%0d", pc, halted);

        // Reset leaves HALT.
        rst = 1'b1;
        #1;
        check("rst2_halted", {31'd0, halted}, 32'd0);
        check("rst2_req", {31'd0, imem_req}, 32'd0);
        check("rst2_pc", pc, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst2_restart", {31'd0, imem_req}, 32'd1);
        check_tc(32'd0);
        branch(32'h0400_0144, 32'd0, 32'd0, 32'd5);

        // Reset while a fetch is stalled with an ack arriving.
        repeat (2) @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0400_0044;
        #1;
        rst = 1'b1;
        #1;
        check("stall_rst_req", {31'd0, imem_req}, 32'd0);
        check("stall_rst_pc", pc, 32'd0);
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        rst        = 1'b0;
        #1;
        check("stall_rel_req", {31'd0, imem_req}, 32'd1);
        check("stall_rel_addr", imem_addr, 32'd0);
        check("stall_rel_ir", ir, 32'd0);
        check_tc(32'd0);
        @(negedge clk);
        check("stall_no_ack_ir", ir, 32'd0);
        $display("reset during stall addr=0x%08h", imem_addr);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Multi-cycle fetch/decode/branch controller that owns the program counter and sequences every instruction through fetch, register read and either branch resolution or datapath execution. It sits between the instruction memory, the register file read port and the ALU/execute datapath, and replaces the free-running PC update with a handshaked state machine. Branch targets are PC-relative, and conditions are evaluated on the rs register value.

## Interface
- `BR_OPC`, default 6'b000001: opcode (instr[31:26]) of the branch class.
- `RESET_PC`, default 32'd0: PC value loaded on reset.
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `imem_req` output, 1 bit: fetch request.
- `imem_addr` output, 32 bits: fetch address; always equals `pc`.
- `imem_ack` input, 1 bit: fetch complete; `imem_rdata` is valid in the same cycle.
- `imem_rdata` input, 32 bits: instruction word.
- `rf_raddr` output, 5 bits: register read address; always equals `ir[25:21]`.
- `rf_rdata` input, 32 bits: combinational read data for `rf_raddr`.
- `exec_start` output, 1 bit: one-cycle pulse that starts a non-branch instruction.
- `exec_done` input, 1 bit: datapath has finished the current instruction.
- `ir` output, 32 bits: instruction register.
- `pc` output, 32 bits: program counter.
- `halted` output, 1 bit: the halt instruction has retired.
- `illegal` output, 1 bit: one-cycle pulse on an unknown branch function code.
- `taken_count` output, 32 bits: count of taken branches. Present only when `BRANCH_PERF_EN` is defined.

## Operation
- The state machine has four states: FETCH, DECODE, EXEC and HALT.
- **FETCH:** `imem_req`=1. When `imem_ack`=1, latch `ir`<=`imem_rdata` and go to DECODE. Otherwise stay in FETCH.
- **DECODE:** one cycle. `rf_rdata` is sampled in this cycle.
  - Branch class (`ir[31:26]`==BR_OPC): resolve the branch, update `pc`, then go to FETCH, or to HALT for the halt function.
  - Otherwise: pulse `exec_start` and go to EXEC.
- **EXEC:** wait for `exec_done`=1, then set `pc`<=`pc`+1 and go to FETCH. If `exec_done` is already high during the DECODE cycle, it is ignored; only `exec_done` seen in EXEC counts.
- **HALT:** terminal state. `halted`=1, no requests are issued. Only `rst` leaves HALT.
- **Branch function codes** (`ir[5:0]`), with offset = sign-extend(`ir[20:6]`) to 32 bits:
  - 6'b000100: always taken.
  - 6'b000101: taken if `rf_rdata[31]`==1.
  - 6'b000110: taken if `rf_rdata[31]`==0 and `rf_rdata`!=0.
  - 6'b000111: taken if `rf_rdata`==0.
  - 6'b111111: halt. `pc` is unchanged.
  - Any other code: not taken, and `illegal` pulses for that DECODE cycle.
- **PC update:** taken gives `pc`+offset; not taken gives `pc`+1. All arithmetic is 32-bit modulo 2^32, so wrap-around is silent (0xFFFFFFFF+1 gives 0).

## Timing
- **Reset values:** state=FETCH, `pc`=RESET_PC, `ir`=0, `imem_req`=0 during reset and 1 from the first cycle after it, `exec_start`=0, `halted`=0, `illegal`=0, `taken_count`=0.
- **Reset mid-operation:** `rst` asserted in any state clears all registers immediately and drops `imem_req`/`exec_start` asynchronously. An in-flight ack is discarded.
- **Branch latency:** minimum 2 cycles (FETCH with zero-wait ack, then DECODE). The new `pc` is visible on `imem_addr` in the next FETCH cycle.
- **Non-branch latency:** minimum 3 cycles: FETCH, then DECODE, then EXEC with `exec_done` in its first cycle.
- `imem_ack` outside FETCH is ignored.
- `exec_start` is high exactly one cycle per non-branch instruction.
- Outputs are registered except `imem_req`, `exec_start` and `illegal`, which decode the current state.

## Configuration
- `BRANCH_PERF_EN`:
  - **Defined:** `taken_count` increments by 1 in each DECODE cycle where a branch is taken. It wraps at 2^32 and is cleared by `rst`.
  - **Undefined:** the port and its counter are absent. All other behaviour is identical.

## Structure
- **Shared package `cpu_ctrl_pkg`:** state enumeration, BR_OPC default, branch function code constants (BR_U, BR_NEG, BR_POS, BR_Z, BR_HALT), and instruction field bit positions.
- **Sub-module `branch_cond_eval`:** purely combinational. It takes func, `rf_rdata`, `pc` and offset, and returns `taken`, `illegal`, `halt` and `next_pc`. It is instantiated once.

## Test plan
- **Zero-wait ack:** instruction 0x0400_0044 (BR_U, offset 1) at pc 0 -> 2 cycles later `imem_addr`=1 and `taken_count`=1.
- **Negative branch:** rs=0x8000_0000, BR_NEG with offset -2 at pc 10 -> `pc`=8. With rs=5 -> `pc`=11.
- **Non-branch with delayed completion:** `exec_done` delayed 4 cycles -> `exec_start` is a single pulse and `pc` increments only after `exec_done`.
- **Wrap-around:** pc=0xFFFF_FFFF executing a non-branch -> next `imem_addr`=0. Separately, BR_Z taken with offset +2 from pc 0xFFFF_FFFF -> `pc`=1.
- **Illegal function code:** func 6'b001000 -> `illegal` pulses for 1 cycle and `pc`+1. Halt function 6'b111111 -> `halted`=1, `imem_req` stays 0 forever, `pc` is unchanged.
- **Reset during stall:** `rst` asserted during FETCH with ack pending -> `imem_req`=0 immediately. After release, fetch restarts at RESET_PC.
